lfsr_stream_checker: RTL and testbench
======================================

LFSR_STREAM_CHECKER -- requirements
Module: lfsr_stream_checker

Interface
REQ-001: Parameter LOSS_THRESH, default 4, is the number of consecutive LOCKED mismatches that forces a return to SEARCH (legal range 1..15).
REQ-002: The block SHALL have a single clock and an asynchronous, active-high reset.
REQ-003: clk  input  1  rising-edge clock for all state.
REQ-004: reset  input  1  asynchronous, active-high reset.
REQ-005: valid  input  1  d carries a stream beat this cycle.
REQ-006: d  input  8  stream beat: low byte of a 16-bit Fibonacci LFSR state.
REQ-007: locked  output  1  high while in LOCKED.
REQ-008: mismatch  output  1  one-cycle pulse per mismatched beat in LOCKED.
REQ-009: expected  output  8  low byte of the prediction used for the most recent beat.
REQ-010: error_count  output  16  saturating count of LOCKED mismatches.

Function
REQ-011: step(S) SHALL be defined as {S[0]^S[2]^S[3]^S[5], S[15:1]}, i.e. the generator advances once per beat.
REQ-012: The block SHALL sample only on cycles with valid=1; valid=0 cycles SHALL change no state and SHALL hold mismatch at 0.
REQ-013: All outputs SHALL be registered and reflect a beat on the cycle after the edge that samples it.
REQ-014: States SHALL be SEARCH, FILL and LOCKED, with a 16-bit predictor register R, a 4-bit fill counter and a 4-bit miss counter.
REQ-015: SEARCH, on a valid beat: R <= {8'h00, d}, fill counter <= 0, go to FILL; no comparison is made.
REQ-016: FILL, on a valid beat: P = step(R); if d[6:0] == P[6:0], R <= {P[15:8], d[7], P[6:0]} and the fill counter increments.
REQ-017: FILL mismatch on d[6:0]: re-seed from the current beat (R <= {8'h00, d}, fill counter <= 0) and stay in FILL; error_count is unaffected.
REQ-018: FILL SHALL transition to LOCKED on the 8th consecutive matching FILL beat, with the miss counter <= 0.
REQ-019: LOCKED, on a valid beat: P = step(R); R <= P, so R free-runs on the prediction and never on d.
REQ-020: In LOCKED, expected <= P[7:0]; if d != P[7:0], mismatch pulses, error_count increments and the miss counter increments; a match clears the miss counter.
REQ-021: When the miss counter reaches LOSS_THRESH, the block SHALL go to SEARCH on that edge and locked SHALL drop the next cycle.
REQ-022: error_count SHALL saturate at 16'hFFFF without wrapping.
REQ-023: expected SHALL hold its value in SEARCH and FILL.

Reset
REQ-024: Reset SHALL immediately force SEARCH, R=0, both counters 0, locked=0, mismatch=0, expected=8'h00 and error_count=0, including mid-FILL or mid-LOCKED.
REQ-025: On the first edge after reset deasserts with valid=1, that beat SHALL be treated as a SEARCH seed.

Configuration
REQ-026: When macro LFSR_CHK_CLEAR_EN is defined, the block SHALL add input port clear (1 bit) that synchronously zeroes error_count on the next edge; state and locked are unaffected.
REQ-027: When clear and a counted mismatch occur in the same cycle, error_count SHALL become 0 (clear wins).
REQ-028: When LFSR_CHK_CLEAR_EN is undefined, the clear port SHALL not exist and error_count SHALL clear only by reset.

Verification
REQ-029: Reset, then 9 valid beats from seed 16'h0001 (d=01, then 00 x8) -> locked=1 the cycle after the 9th beat; error_count=0.
REQ-030: Locked, next beat d=8'h80 -> expected=8'h80, mismatch stays 0; 500 further clean beats -> error_count=0.
REQ-031: Locked, one beat XORed with 8'h01 -> mismatch high exactly one cycle, error_count=1, locked stays 1, later clean beats match.
REQ-032: LOSS_THRESH=4: 3 consecutive corrupted beats then clean -> locked stays 1, error_count=3; 4 consecutive -> locked=0 after the 4th, error_count=4, re-lock after 9 clean beats.
REQ-033: Random valid=0 gaps inserted in the scenario 1/2 stream -> identical locked, expected and error_count results; assert reset during FILL -> locked=0 and the next beat re-seeds.
REQ-034: With LFSR_CHK_CLEAR_EN: error_count=5, pulse clear -> 0 next cycle; clear coincident with a mismatch -> 0.

Source files
------------

// File: rtl/lfsr_stream_checker.sv
// Locks onto a stream of low bytes of a 16-bit Fibonacci LFSR and counts beats that diverge from the prediction.
// Optional synchronous error_count clear port is enabled by defining LFSR_CHK_CLEAR_EN.
module lfsr_stream_checker #(
    parameter int unsigned LOSS_THRESH = 4
) (
    input  logic        clk,
    input  logic        reset,
`ifdef LFSR_CHK_CLEAR_EN
    input  logic        clear,
`endif
    input  logic        valid,
    input  logic [7:0]  d,
    output logic        locked,
    output logic        mismatch,
    output logic [7:0]  expected,
    output logic [15:0] error_count
);

    localparam logic [3:0] THRESH = 4'(LOSS_THRESH);

    typedef enum logic [1:0] {
        SEARCH,
        FILL,
        LOCKED
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] r, r_nxt, p;
    logic [3:0]  fill_cnt, fill_nxt;
    logic [3:0]  miss_cnt, miss_nxt, miss_inc;
    logic        locked_nxt, mismatch_nxt;
    logic [7:0]  expected_nxt;
    logic [15:0] err_nxt;
    logic        clear_i;

`ifdef LFSR_CHK_CLEAR_EN
    assign clear_i = clear;
`else
    assign clear_i = 1'b0;
`endif

    assign p        = {r[0] ^ r[2] ^ r[3] ^ r[5], r[15:1]};
    assign miss_inc = miss_cnt + 4'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= SEARCH;
            r           <= '0;
            fill_cnt    <= '0;
            miss_cnt    <= '0;
            locked      <= 1'b0;
            mismatch    <= 1'b0;
            expected    <= '0;
            error_count <= '0;
        end else begin
            state       <= state_nxt;
            r           <= r_nxt;
            fill_cnt    <= fill_nxt;
            miss_cnt    <= miss_nxt;
            locked      <= locked_nxt;
            mismatch    <= mismatch_nxt;
            expected    <= expected_nxt;
            error_count <= err_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        r_nxt        = r;
        fill_nxt     = fill_cnt;
        miss_nxt     = miss_cnt;
        mismatch_nxt = 1'b0;
        expected_nxt = expected;
        err_nxt      = error_count;

        if (valid) begin
            case (state)
                SEARCH: begin
                    r_nxt     = {8'h00, d};
                    fill_nxt  = '0;
                    state_nxt = FILL;
                end
                FILL: begin
                    // Bit 7 of the prediction comes from unseeded upper bits, so it is learned from d.
                    if (d[6:0] == p[6:0]) begin
                        r_nxt    = {p[15:8], d[7], p[6:0]};
                        fill_nxt = fill_cnt + 4'd1;
                        if (fill_cnt == 4'd7) begin
                            state_nxt = LOCKED;
                            miss_nxt  = '0;
                        end
                    end else begin
                        r_nxt    = {8'h00, d};
                        fill_nxt = '0;
                    end
                end
                LOCKED: begin
                    r_nxt        = p;
                    expected_nxt = p[7:0];
                    if (d != p[7:0]) begin
                        mismatch_nxt = 1'b1;
                        miss_nxt     = miss_inc;
                        if (error_count != '1)
                            err_nxt = error_count + 16'd1;
                        if (miss_inc == THRESH)
                            state_nxt = SEARCH;
                    end else begin
                        miss_nxt = '0;
                    end
                end
                default: state_nxt = SEARCH;
            endcase
        end

        if (clear_i)
            err_nxt = '0;

        locked_nxt = (state_nxt == LOCKED);
    end

endmodule

// File: tb/tb_lfsr_stream_checker.sv
// Randomised self-checking bench for lfsr_stream_checker against a behavioural reference model.
// Define LFSR_CHK_CLEAR_EN to also exercise the clear port.
module tb_lfsr_stream_checker;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid = 1'b0;
    logic        clear = 1'b0;
    logic [7:0]  d = '0;
    logic        locked, mismatch;
    logic [7:0]  expected;
    logic [15:0] error_count;

    lfsr_stream_checker #(.LOSS_THRESH(4)) dut (
        .clk         (clk),
        .reset       (reset),
`ifdef LFSR_CHK_CLEAR_EN
        .clear       (clear),
`endif
        .valid       (valid),
        .d           (d),
        .locked      (locked),
        .mismatch    (mismatch),
        .expected    (expected),
        .error_count (error_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Reference model: generator advance via tap-mask parity, mode tracked as a plain enum.
    typedef enum {M_SEARCH, M_FILL, M_LOCKED} mode_t;
    mode_t       m_mode;
    logic [15:0] m_r;
    int          m_fill, m_miss, m_err;
    logic        m_mis;
    logic [7:0]  m_exp;
    logic [15:0] g;

    function automatic logic [15:0] advance(input logic [15:0] s);
        logic fb;
        fb = 1'($countones(s & 16'h002D) % 2);
        return {fb, s[15:1]};
    endfunction

    task automatic m_reset();
        m_mode = M_SEARCH; m_r = '0; m_fill = 0; m_miss = 0;
        m_err = 0; m_mis = 1'b0; m_exp = '0;
    endtask

    task automatic model_step(input logic v, input logic [7:0] dv, input logic clr);
        logic [15:0] pr;
        m_mis = 1'b0;
        if (v) begin
            pr = advance(m_r);
            if (m_mode == M_SEARCH) begin
                m_r = {8'h00, dv}; m_fill = 0; m_mode = M_FILL;
            end else if (m_mode == M_FILL) begin
                if (dv[6:0] == pr[6:0]) begin
                    m_r = {pr[15:8], dv[7], pr[6:0]};
                    m_fill++;
                    if (m_fill == 8) begin m_mode = M_LOCKED; m_miss = 0; end
                end else begin
                    m_r = {8'h00, dv}; m_fill = 0;
                end
            end else begin
                m_r = pr; m_exp = pr[7:0];
                if (dv != pr[7:0]) begin
                    m_mis = 1'b1;
                    if (m_err < 65535) m_err++;
                    m_miss++;
                    if (m_miss == 4) m_mode = M_SEARCH;
                end else m_miss = 0;
            end
        end
        if (clr) m_err = 0;
    endtask

    task automatic cycle(input logic v, input logic [7:0] dv, input logic clr);
        @(negedge clk);
        valid = v; d = dv; clear = clr;
        @(posedge clk);
        #1;
        model_step(v, dv, clr);
        valid = 1'b0; clear = 1'b0;
        check("locked", locked, m_mode == M_LOCKED);
        check("mismatch", mismatch, m_mis);
        check("expected", expected, m_exp);
        check("error_count", error_count, m_err);
    endtask

    // One generator beat, optionally corrupted, optionally preceded by an idle gap.
    task automatic send(input logic [7:0] mask, input bit gaps);
        if (gaps && $urandom_range(0, 3) == 0) begin
            for (int i = 0; i < int'($urandom_range(1, 3)); i++)
                cycle(1'b0, 8'($urandom), 1'b0);
        end
        cycle(1'b1, g[7:0] ^ mask, 1'b0);
        g = advance(g);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        m_reset();
        check("rst_locked", locked, 0);
        check("rst_mismatch", mismatch, 0);
        check("rst_expected", expected, 0);
        check("rst_error_count", error_count, 0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        m_reset();
        repeat (3) @(posedge clk);
        do_reset();

        // Seed 16'h0001: d=01 then eight 00 beats
        g = 16'h0001;
        for (int i = 0; i < 8; i++) send(8'h00, 1'b0);
        check("not_locked_8", locked, 0);
        send(8'h00, 1'b0);
        check("locked_9", locked, 1);
        check("err_after_lock", error_count, 0);
        send(8'h00, 1'b0);
        check("expected_80", expected, 8'h80);
        check("no_mismatch_80", mismatch, 0);

        for (int i = 0; i < 500; i++) send(8'h00, 1'b1);
        check("clean_500_err", error_count, 0);
        check("clean_500_locked", locked, 1);

        send(8'h01, 1'b0);
        check("single_mis", mismatch, 1);
        check("single_err", error_count, 1);
        check("single_locked", locked, 1);
        cycle(1'b0, 8'h00, 1'b0);
        check("mis_one_cycle", mismatch, 0);
        for (int i = 0; i < 5; i++) send(8'h00, 1'b0);
        check("after_single_err", error_count, 1);

        for (int i = 0; i < 3; i++) send(8'h01, 1'b0);
        send(8'h00, 1'b0);
        check("three_miss_locked", locked, 1);
        check("three_miss_err", error_count, 4);

        for (int i = 0; i < 4; i++) send(8'h01, 1'b0);
        check("four_miss_unlocked", locked, 0);
        check("four_miss_err", error_count, 8);
        for (int i = 0; i < 8; i++) send(8'h00, 1'b0);
        check("relock_not_yet", locked, 0);
        send(8'h00, 1'b0);
        check("relock_9", locked, 1);

        // Reset asserted mid-FILL; the next beat must seed again
        do_reset();
        for (int i = 0; i < 3; i++) send(8'h00, 1'b1);
        do_reset();
        for (int i = 0; i < 8; i++) send(8'h00, 1'b1);
        check("fill_reset_not_yet", locked, 0);
        send(8'h00, 1'b1);
        check("fill_reset_relock", locked, 1);

        for (int i = 0; i < 2000; i++) begin
            logic [7:0] m;
            m = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            send(m, 1'b1);
        end

`ifdef LFSR_CHK_CLEAR_EN
        do_reset();
        for (int i = 0; i < 9; i++) send(8'h00, 1'b0);
        for (int i = 0; i < 5; i++) begin
            send(8'h01, 1'b0);
            send(8'h00, 1'b0);
        end
        check("clr_pre_err", error_count, 5);
        cycle(1'b0, 8'h00, 1'b1);
        check("clr_zero", error_count, 0);
        check("clr_locked", locked, 1);
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        @(negedge clk);
        valid = 1'b1; d = g[7:0] ^ 8'h04; clear = 1'b1;
        @(posedge clk);
        #1;
        model_step(1'b1, g[7:0] ^ 8'h04, 1'b1);
        g = advance(g);
        valid = 1'b0; clear = 1'b0;
        check("clr_coinc_mis", mismatch, 1);
        check("clr_coinc_err", error_count, 0);
        check("clr_coinc_locked", locked, 1);
`endif

        do_reset();
        check("final_locked", locked, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
